gpio_in_debounce: RTL and testbench

Input-conditioning stage between the FPGA `gpio` pads and the SoC's `gp_in` port, placed in the top-level GPIO (de)mux path. Each bit passes through a synchronizer and a tick-sampled debounce filter that requires N consecutive stable samples. The block presents clean levels to the SoC, plus one-cycle rise/fall pulses for future interrupt use. Bits configured as outputs are masked, and selected bits can bypass the filter.

---
 rtl/gpio_in_debounce_if.sv | 30 +++
 rtl/gpio_in_debounce.sv | 117 +++++++++++
 tb/tb_gpio_in_debounce.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_in_debounce_if.sv
// Pad-side and SoC-side signal bundle for the GPIO input conditioning stage.
// The slave modport is the conditioning block; master is whoever drives pads/oe.
interface gpio_in_debounce_if #(
  parameter int unsigned WIDTH = 24
);
  logic [WIDTH-1:0] gpio_raw;
  logic [WIDTH-1:0] gp_oe;
  logic [WIDTH-1:0] gp_in;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;
  logic             any_edge;

  modport master (
    output gpio_raw,
    output gp_oe,
    input  gp_in,
    input  rise_pulse,
    input  fall_pulse,
    input  any_edge
  );

  modport slave (
    input  gpio_raw,
    input  gp_oe,
    output gp_in,
    output rise_pulse,
    output fall_pulse,
    output any_edge
  );
endinterface

// File: rtl/gpio_in_debounce.sv
// Per-bit synchronizer plus tick-sampled debounce filter feeding clean GPIO levels
// and one-cycle edge pulses to the SoC; output-enabled bits are held at 0.
//
// Per-bit filter state (encoded by the qualification counter):
//   state      | meaning
//   STABLE     | cnt == 0, gp_in matches the last qualified level
//   QUALIFYING | cnt  > 0, sampled level differs, counting consecutive ticks
module gpio_in_debounce #(
  parameter int unsigned      WIDTH        = 24,
  parameter int unsigned      SYNC_STAGES  = 2,
  parameter int unsigned      TICK_DIV     = 1000,
  parameter int unsigned      STABLE_TICKS = 4,
  parameter logic [WIDTH-1:0] BYPASS_MASK  = '0
) (
  input  logic                ext_clk_100,
  input  logic                ext_rst_n,
  gpio_in_debounce_if.slave   bus
);

  localparam int unsigned     PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned     CW       = $clog2(STABLE_TICKS + 1);
  localparam logic [PW-1:0]   PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_TICKS - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_s;

  logic [PW-1:0]    pre_q, pre_d;
  logic             tick;

  logic [WIDTH-1:0] lvl_q, lvl_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;

  always_ff @(posedge ext_clk_100 or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= bus.gpio_raw;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Free-running prescaler; with TICK_DIV == 1 it stays at 0 and ticks every cycle.
  assign tick  = (pre_q == PRE_LAST);
  assign pre_d = tick ? '0 : pre_q + PW'(1);

  always_ff @(posedge ext_clk_100 or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  always_comb begin
    lvl_d  = lvl_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (bus.gp_oe[i]) begin
        // Forced low every cycle; the bit requalifies from scratch afterwards.
        lvl_d[i] = 1'b0;
        cnt_d[i] = '0;
      end else if (BYPASS_MASK[i]) begin
        lvl_d[i]  = sync_s[i];
        cnt_d[i]  = '0;
        rise_d[i] = sync_s[i] & ~lvl_q[i];
        fall_d[i] = ~sync_s[i] & lvl_q[i];
      end else if (tick) begin
        if (sync_s[i] == lvl_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          lvl_d[i]  = sync_s[i];
          cnt_d[i]  = '0;
          rise_d[i] = sync_s[i];
          fall_d[i] = ~sync_s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge ext_clk_100 or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      lvl_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.gp_in      = lvl_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
  assign bus.any_edge   = |(rise_q | fall_q);

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Directed bench for gpio_in_debounce: reset, filtered step, glitch rejection,
// bypass path, output-enable forcing and mid-qualification reset.
module tb_gpio_in_debounce;

  logic ext_clk_100;
  logic ext_rst_n;

  gpio_in_debounce_if #(.WIDTH(24)) bus ();

  gpio_in_debounce #(
    .WIDTH        (24),
    .SYNC_STAGES  (2),
    .TICK_DIV     (4),
    .STABLE_TICKS (3),
    .BYPASS_MASK  (24'h800000)
  ) dut (
    .ext_clk_100 (ext_clk_100),
    .ext_rst_n   (ext_rst_n),
    .bus         (bus)
  );

  initial begin
    ext_clk_100 = 1'b0;
    forever #5 ext_clk_100 = ~ext_clk_100;
  end

  int          checks;
  int          errors;
  int          ecnt;
  int          any_cnt;
  int          n;
  logic [23:0] rise_acc;
  logic [23:0] fall_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // One clock edge, then sample 1 ns later and accumulate pulse activity.
  task automatic step();
    @(posedge ext_clk_100);
    #1;
    ecnt++;
    rise_acc = rise_acc | bus.rise_pulse;
    fall_acc = fall_acc | bus.fall_pulse;
    if (bus.any_edge) any_cnt++;
  endtask

  task automatic clear_acc();
    rise_acc = '0;
    fall_acc = '0;
    any_cnt  = 0;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    ecnt         = 0;
    clear_acc();
    bus.gpio_raw = '0;
    bus.gp_oe    = '0;
    ext_rst_n    = 1'b1;

    // Reset asserted before any clock edge
    #1;
    bus.gpio_raw = 24'hFFFFFF;
    ext_rst_n    = 1'b0;
    #1;
    chk("rst_gp_in",    bus.gp_in,      '0);
    chk("rst_rise",     bus.rise_pulse, '0);
    chk("rst_fall",     bus.fall_pulse, '0);
    chk("rst_any_edge", bus.any_edge,   '0);

    repeat (3) step();
    bus.gpio_raw = '0;
    ext_rst_n    = 1'b1;
    ecnt         = 0;
    clear_acc();
    repeat (100) step();
    chk("idle_gp_in", bus.gp_in, '0);
    chk("idle_rise",  rise_acc,  '0);
    chk("idle_fall",  fall_acc,  '0);

    // Filtered step on bit 0
    bus.gpio_raw[0] = 1'b1;
    n = 0;
    while (n < 40 && !bus.gp_in[0]) begin
      step();
      n++;
    end
    chk_rng("step_rise_latency", n, 11, 14);
    chk("step_rise_pulse", bus.rise_pulse, 24'h000001);
    chk("step_rise_nofall", bus.fall_pulse, '0);
    chk("step_rise_any", bus.any_edge, 1'b1);
    step();
    chk("step_rise_pulse_end", bus.rise_pulse, '0);
    chk("step_rise_any_end", bus.any_edge, 1'b0);
    chk("step_rise_level", bus.gp_in, 24'h000001);

    bus.gpio_raw[0] = 1'b0;
    n = 0;
    while (n < 40 && bus.gp_in[0]) begin
      step();
      n++;
    end
    chk_rng("step_fall_latency", n, 11, 14);
    chk("step_fall_pulse", bus.fall_pulse, 24'h000001);
    chk("step_fall_norise", bus.rise_pulse, '0);
    step();
    chk("step_fall_pulse_end", bus.fall_pulse, '0);

    // 6-cycle glitch on bit 5 can span at most two ticks
    clear_acc();
    bus.gpio_raw[5] = 1'b1;
    repeat (6) step();
    bus.gpio_raw[5] = 1'b0;
    repeat (30) step();
    chk("glitch6_level", bus.gp_in, '0);
    chk("glitch6_rise",  rise_acc,  '0);
    chk("glitch6_fall",  fall_acc,  '0);

    // 7 high / 1 low / 7 high, phased so the low sample lands on a tick
    n = 0;
    while (n < 8 && (ecnt % 4) != 2) begin
      step();
      n++;
    end
    clear_acc();
    bus.gpio_raw[5] = 1'b1;
    repeat (7) step();
    bus.gpio_raw[5] = 1'b0;
    step();
    bus.gpio_raw[5] = 1'b1;
    repeat (7) step();
    bus.gpio_raw[5] = 1'b0;
    repeat (30) step();
    chk("glitch771_level", bus.gp_in, '0);
    chk("glitch771_rise",  rise_acc,  '0);
    chk("glitch771_fall",  fall_acc,  '0);

    // Bypass bit 23: pad to gp_in in exactly 3 edges
    bus.gpio_raw[23] = 1'b1;
    step();
    chk("bypass_e1", bus.gp_in[23], 1'b0);
    step();
    chk("bypass_e2", bus.gp_in[23], 1'b0);
    step();
    chk("bypass_e3", bus.gp_in[23], 1'b1);
    chk("bypass_rise", bus.rise_pulse, 24'h800000);
    step();
    chk("bypass_rise_end", bus.rise_pulse, '0);
    bus.gpio_raw[23] = 1'b0;
    repeat (5) step();
    chk("bypass_low", bus.gp_in[23], 1'b0);

    bus.gpio_raw[23] = 1'b1;
    step();
    bus.gpio_raw[23] = 1'b0;
    step();
    step();
    chk("bypass_glitch_hi", bus.gp_in[23], 1'b1);
    chk("bypass_glitch_rise", bus.rise_pulse, 24'h800000);
    step();
    chk("bypass_glitch_lo", bus.gp_in[23], 1'b0);
    chk("bypass_glitch_fall", bus.fall_pulse, 24'h800000);
    chk("bypass_glitch_norise", bus.rise_pulse, '0);
    step();
    chk("bypass_glitch_fall_end", bus.fall_pulse, '0);

    // Output enable forcing on bit 3
    bus.gpio_raw[3] = 1'b1;
    repeat (20) step();
    chk("oe_pre_level", bus.gp_in, 24'h000008);
    clear_acc();
    bus.gp_oe[3] = 1'b1;
    step();
    chk("oe_forced_low", bus.gp_in[3], 1'b0);
    repeat (5) step();
    chk("oe_no_fall", fall_acc, '0);
    chk("oe_no_rise", rise_acc, '0);
    bus.gp_oe[3] = 1'b0;
    n = 0;
    while (n < 40 && !bus.gp_in[3]) begin
      step();
      n++;
    end
    chk_rng("oe_requal_latency", n, 9, 12);
    chk("oe_requal_rise", bus.rise_pulse, 24'h000008);

    // Bits 0-7 step together
    bus.gpio_raw[7:0] = 8'h00;
    repeat (20) step();
    chk("multi_pre_level", bus.gp_in, '0);
    clear_acc();
    bus.gpio_raw[7:0] = 8'hFF;
    n = 0;
    while (n < 40 && !bus.gp_in[0]) begin
      step();
      n++;
    end
    chk("multi_level", bus.gp_in, 24'h0000FF);
    chk("multi_rise", bus.rise_pulse, 24'h0000FF);
    chk("multi_any", bus.any_edge, 1'b1);
    repeat (10) step();
    chk("multi_any_count", any_cnt, 1);

    // Reset in the middle of qualification
    bus.gpio_raw[7:0] = 8'h00;
    repeat (20) step();
    bus.gpio_raw[7:0] = 8'hFF;
    repeat (6) step();
    chk("midq_pre_level", bus.gp_in, '0);
    #2;
    ext_rst_n = 1'b0;
    #1;
    chk("midq_rst_gp_in", bus.gp_in,      '0);
    chk("midq_rst_rise",  bus.rise_pulse, '0);
    chk("midq_rst_any",   bus.any_edge,   1'b0);
    #2;
    ext_rst_n = 1'b1;
    ecnt      = 0;
    n = 0;
    while (n < 40 && !bus.gp_in[0]) begin
      step();
      n++;
    end
    chk("midq_requal_latency", n, 12);
    chk("midq_requal_rise", bus.rise_pulse, 24'h0000FF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
